param_seq_detector: RTL and testbench

Runtime-programmable serial bit-pattern detector. It generalises the fixed Moore "1100" and Mealy "1101" detectors into one block with a configurable pattern width, a selectable Moore/Mealy output mode, a selectable overlap mode and a saturating match counter. It sits on a 1-bit serial input stream, gated by a valid qualifier, and feeds status and event logic downstream.

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/seq_shift_hist.sv | 44 ++++
 rtl/param_seq_detector.sv | 101 ++++++++++
 tb/tb_param_seq_detector.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial pattern detector.
//   mode_e      : output timing mode (Moore registered / Mealy combinational)
//   DEF_PATTERN : pattern loaded at reset (widest legal pattern, truncated by users)
//   fill_w()    : width of the history fill counter for a given pattern length
package seq_det_pkg;

  typedef enum logic {
    MODE_MOORE = 1'b0,
    MODE_MEALY = 1'b1
  } mode_e;

  localparam logic [15:0] DEF_PATTERN = '0;

  function automatic int unsigned fill_w(input int unsigned pat_w);
    return $clog2(pat_w);
  endfunction

endpackage

// File: rtl/seq_shift_hist.sv
// Serial history shifter with fill tracking.
//   clk, reset : clock, asynchronous active-low reset
//   shift_en   : shift seq_in into the history this cycle
//   clear      : discard history and restart filling (wins over shift_en)
//   seq_in     : serial data bit
//   hist       : last PAT_W bits, newest in bit 0
//   full       : PAT_W-1 bits collected, so the next valid bit completes a window
module seq_shift_hist
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             seq_in,
  output logic [PAT_W-1:0] hist,
  output logic             full
);

  localparam int unsigned          FILL_W   = fill_w(PAT_W);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PAT_W - 1);

  logic [FILL_W-1:0] fill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= {hist[PAT_W-2:0], seq_in};
      if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  assign full = (fill == FILL_MAX);

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial bit-pattern detector.
//   clk, reset   : clock, asynchronous active-low reset
//   seq_in       : serial data, qualified by in_valid
//   cfg_load     : strobe latching cfg_pattern (MSB first), cfg_mealy, cfg_overlap
//   clr_count    : synchronous clear of match_count / count_sat
//   detected     : match indication (same cycle in Mealy, next cycle in Moore)
//   match_count  : saturating number of matches
//   count_sat    : sticky, set when match_count reaches all-ones
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seq_in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_mealy,
  input  logic             cfg_overlap,
  input  logic             clr_count,
  output logic             detected,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

  logic [PAT_W-1:0] pat_q;
  mode_e            mode_q;
  logic             overlap_q;
  logic             moore_q;
  logic [PAT_W-1:0] hist;
  logic             full;
  logic             match_now;
  logic             hist_clear;
  logic             unused_hist_msb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q     <= DEF_PATTERN[PAT_W-1:0];
      mode_q    <= MODE_MOORE;
      overlap_q <= 1'b0;
    end else if (cfg_load) begin
      pat_q     <= cfg_pattern;
      mode_q    <= mode_e'(cfg_mealy);
      overlap_q <= cfg_overlap;
    end
  end

  // Non-overlap restart clears the whole history as well as fill; the stale
  // bits are never compared because a window needs PAT_W-1 fresh bits first.
  assign hist_clear = cfg_load | (match_now & ~overlap_q);

  seq_shift_hist #(
    .PAT_W (PAT_W)
  ) u_hist (
    .clk      (clk),
    .reset    (reset),
    .shift_en (in_valid),
    .clear    (hist_clear),
    .seq_in   (seq_in),
    .hist     (hist),
    .full     (full)
  );

  // Oldest history bit has already left the window once the new bit arrives.
  assign unused_hist_msb = hist[PAT_W-1];

  assign match_now = in_valid & ~cfg_load & full &
                     ({hist[PAT_W-2:0], seq_in} == pat_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      moore_q <= 1'b0;
    end else begin
      moore_q <= match_now;
    end
  end

  assign detected = (mode_q == MODE_MEALY) ? match_now : moore_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (clr_count) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (match_now && (match_count != CNT_MAX)) begin
      match_count <= match_count + 1'b1;
      if (match_count == CNT_LAST) begin
        count_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_param_seq_detector.sv
module tb_param_seq_detector;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             seq_in;
  logic             in_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_mealy;
  logic             cfg_overlap;
  logic             clr_count;
  logic             detected;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic        mealy_mode = 1'b0;

  param_seq_detector #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seq_in      (seq_in),
    .in_valid    (in_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_mealy   (cfg_mealy),
    .cfg_overlap (cfg_overlap),
    .clr_count   (clr_count),
    .detected    (detected),
    .match_count (match_count),
    .count_sat   (count_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [PAT_W-1:0] pat, input logic mealy, input logic ovl,
                      input logic v, input logic b);
    cfg_pattern = pat;
    cfg_mealy   = mealy;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    in_valid    = v;
    seq_in      = b;
    tick();
    cfg_load    = 1'b0;
    in_valid    = 1'b0;
    mealy_mode  = mealy;
  endtask

  task automatic clear_count();
    clr_count = 1'b1;
    in_valid  = 1'b0;
    tick();
    clr_count = 1'b0;
  endtask

  // Mealy: detected checked while the bit is presented; Moore: after the edge.
  task automatic step(input logic v, input logic b, input logic exp, input string tag);
    in_valid = v;
    seq_in   = b;
    if (mealy_mode) begin
      #1;
      check({tag, "_det"}, 32'(detected), 32'(exp));
      tick();
    end else begin
      tick();
      check({tag, "_det"}, 32'(detected), 32'(exp));
    end
  endtask

  task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] exp,
                        input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i], exp[n-1-i], $sformatf("%s_b%0d", tag, i));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    seq_in      = 1'b0;
    in_valid    = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_mealy   = 1'b0;
    cfg_overlap = 1'b0;
    clr_count   = 1'b0;
    tick();
    tick();
    check("rst_det", 32'(detected), 32'd0);
    check("rst_cnt", 32'(match_count), 32'd0);
    check("rst_sat", 32'(count_sat), 32'd0);
    reset = 1'b1;
    tick();

    // Moore 1100, non-overlap
    load(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(16'b1100, 4, 16'b0001, "t1");
    check("t1_cnt", 32'(match_count), 32'd1);

    // Mealy 1101; the 1 presented during the load cycle must be discarded
    load(4'b1101, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    check("t2_load_det", 32'(detected), 32'd0);
    stream(16'b1011101, 7, 16'b0000001, "t2");
    #1;
    check("t2_idle_det", 32'(detected), 32'd0);
    check("t2_cnt", 32'(match_count), 32'd2);

    // 1010 overlap vs non-overlap
    clear_count();
    check("t3_clr", 32'(match_count), 32'd0);
    load(4'b1010, 1'b0, 1'b1, 1'b0, 1'b0);
    stream(16'b101010, 6, 16'b000101, "t3o");
    check("t3o_cnt", 32'(match_count), 32'd2);
    clear_count();
    load(4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(16'b101010, 6, 16'b000100, "t3n");
    check("t3n_cnt", 32'(match_count), 32'd1);

    // 1100 with invalid gaps carrying bits that would break the pattern
    clear_count();
    load(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, "t4_0");
    step(1'b0, 1'b0, 1'b0, "t4_1");
    step(1'b1, 1'b1, 1'b0, "t4_2");
    step(1'b0, 1'b0, 1'b0, "t4_3");
    step(1'b0, 1'b0, 1'b0, "t4_4");
    step(1'b1, 1'b0, 1'b0, "t4_5");
    step(1'b1, 1'b0, 1'b1, "t4_6");
    step(1'b0, 1'b0, 1'b0, "t4_7");
    check("t4_cnt", 32'(match_count), 32'd1);

    // Saturation with 1111 overlapping
    clear_count();
    load(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
    stream(16'b11111, 5, 16'b00011, "t5a");
    check("t5a_cnt", 32'(match_count), 32'd2);
    check("t5a_sat", 32'(count_sat), 32'd0);
    stream(16'b1, 1, 16'b1, "t5b");
    check("t5b_cnt", 32'(match_count), 32'd3);
    check("t5b_sat", 32'(count_sat), 32'd1);
    stream(16'b11, 2, 16'b11, "t5c");
    check("t5c_cnt", 32'(match_count), 32'd3);
    check("t5c_sat", 32'(count_sat), 32'd1);
    clr_count = 1'b1;
    in_valid  = 1'b1;
    seq_in    = 1'b1;
    tick();
    clr_count = 1'b0;
    in_valid  = 1'b0;
    check("t5d_cnt", 32'(match_count), 32'd0);
    check("t5d_sat", 32'(count_sat), 32'd0);
    check("t5d_det", 32'(detected), 32'd1);
    step(1'b1, 1'b1, 1'b1, "t5e");
    in_valid = 1'b0;
    check("t5e_cnt", 32'(match_count), 32'd1);

    // Async reset while a Mealy match is being presented
    load(4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);
    stream(16'b110, 3, 16'b000, "t6");
    in_valid = 1'b1;
    seq_in   = 1'b1;
    #1;
    check("t6_pre_det", 32'(detected), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("t6_rst_det", 32'(detected), 32'd0);
    check("t6_rst_cnt", 32'(match_count), 32'd0);
    check("t6_rst_sat", 32'(count_sat), 32'd0);
    in_valid = 1'b0;
    tick();
    tick();
    reset      = 1'b1;
    mealy_mode = 1'b0;
    // Back to reset config: Moore, pattern 0000, empty history
    step(1'b1, 1'b0, 1'b0, "t6_z0");
    step(1'b1, 1'b0, 1'b0, "t6_z1");
    step(1'b1, 1'b0, 1'b0, "t6_z2");
    step(1'b1, 1'b0, 1'b1, "t6_z3");
    in_valid = 1'b0;
    check("t6_z_cnt", 32'(match_count), 32'd1);
    load(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(16'b1100, 4, 16'b0001, "t6_p");
    check("t6_p_cnt", 32'(match_count), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
